// File: rtl/thermo_pkg.sv
// Shared types and helpers for the thermostat bar-graph ramp: state encoding,
// one-hot validation and thermometer encoding sized for the largest supported build.
package thermo_pkg;

    localparam int MAX_LEVELS = 16;
    localparam int IDX_W      = $clog2(MAX_LEVELS);
    localparam int MAX_BAR_W  = 2 * MAX_LEVELS;
    localparam int CNT_W      = $clog2(MAX_BAR_W + 1);

    typedef enum logic [2:0] {IDLE, RAMP_UP, RAMP_DN, HOLD, FAULT} state_t;

    typedef struct packed {
        logic             valid;
        logic [IDX_W-1:0] idx;
    } level_t;

    // Zero or one bit set is valid; idx is the highest set bit (meaningful when valid).
    function automatic level_t onehot_valid(input logic [MAX_LEVELS-1:0] vec);
        level_t res;
        int     ones;
        res  = '0;
        ones = 0;
        for (int i = 0; i < MAX_LEVELS; i++) begin
            if (vec[i]) begin
                ones++;
                res.idx = IDX_W'(i);
            end
        end
        res.valid = (ones <= 1);
        return res;
    endfunction

    function automatic logic [MAX_BAR_W-1:0] therm_code(input logic [CNT_W-1:0] count,
                                                        input int bar_w);
        logic [MAX_BAR_W-1:0] code;
        code = '0;
        for (int i = 0; i < MAX_BAR_W; i++) begin
            code[i] = (i < int'(count)) && (i < bar_w);
        end
        return code;
    endfunction

endpackage

// File: rtl/thermo_level_decode.sv
// Combinational decode of the one-hot demand code into a validity flag and a
// bar-count target; turbo adds one bar to any non-OFF level.
module thermo_level_decode
    import thermo_pkg::*;
#(
    parameter int LEVELS = 4,
    parameter int CW     = 4
) (
    input  logic [LEVELS-1:0] thermo,
    input  logic              turbo,
    output logic              valid,
    output logic [CW-1:0]     target
);

    level_t lv;

    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        lv     = onehot_valid(MAX_LEVELS'(thermo));
        valid  = lv.valid;
        target = '0;
        if (thermo != '0) begin
            target = CW'(2 * int'(lv.idx) + 1 + int'(turbo));
        end
    end

endmodule

// File: rtl/thermo_ramp_bargraph.sv
// Soft-ramping thermometer bar graph with time-limited turbo and a glitch-filtered
// fault mode; all sequential state lives here, decode is in thermo_level_decode.
module thermo_ramp_bargraph
    import thermo_pkg::*;
#(
    parameter int LEVELS    = 4,
    parameter int BAR_W     = 2 * LEVELS,
    parameter int RAMP_DIV  = 4,
    parameter int TURBO_MAX = 64,
    parameter int ERR_CYC   = 3
) (
    input  logic              Clk_in,
    input  logic              Rst_in,
    input  logic [LEVELS-1:0] Thermo_in,
    input  logic              Turbo_in,
    output logic [BAR_W-1:0]  BGraph_out,
    output logic              Err_out,
    output logic              TurboAct_out,
    output logic              Busy_out
);

    localparam int CW    = $clog2(BAR_W + 1);
    localparam int DIV_W = (RAMP_DIV > 1) ? $clog2(RAMP_DIV) : 1;
    localparam int TRB_W = (TURBO_MAX > 0) ? $clog2(TURBO_MAX + 1) : 1;
    localparam int ERR_W = (ERR_CYC > 1) ? $clog2(ERR_CYC) : 1;

    state_t             state, state_next;
    logic [CW-1:0]      count, count_next, target, target_next, dec_target;
    logic [DIV_W-1:0]   div_cnt, div_next;
    logic [TRB_W-1:0]   turbo_cnt, turbo_cnt_next;
    logic [ERR_W-1:0]   err_cnt, err_cnt_next;
    logic               armed, armed_next, turbo_next, code_valid, in_fault, fault_next;

    thermo_level_decode #(.LEVELS(LEVELS), .CW(CW)) u_decode (
        .thermo (Thermo_in),
        .turbo  (TurboAct_out),
        .valid  (code_valid),
        .target (dec_target)
    );

    assign in_fault = (state == FAULT);

    always_comb begin
        fault_next     = in_fault;
        err_cnt_next   = '0;
        target_next    = target;
        count_next     = count;
        div_next       = '0;
        armed_next     = armed;
        turbo_next     = 1'b0;
        turbo_cnt_next = turbo_cnt;
        state_next     = state;

        // One filter counter serves both directions: it counts cycles that argue for leaving the current mode.
        if (in_fault == code_valid) begin
            if (err_cnt == ERR_W'(ERR_CYC - 1)) begin
                fault_next = !in_fault;
            end else begin
                err_cnt_next = err_cnt + ERR_W'(1);
            end
        end

        if (in_fault) begin
            target_next = '0;
        end else if (code_valid) begin
            target_next = dec_target;
        end

        if (count != target) begin
            if (div_cnt == DIV_W'(RAMP_DIV - 1)) begin
                count_next = (count < target) ? count + CW'(1) : count - CW'(1);
            end else begin
                div_next = div_cnt + DIV_W'(1);
            end
        end

        if (!Turbo_in) begin
            armed_next     = 1'b1;
            turbo_cnt_next = '0;
        end else if (in_fault || !armed) begin
            turbo_next = 1'b0;
        end else if (TURBO_MAX == 0) begin
            turbo_next = 1'b1;
        end else if (TurboAct_out && turbo_cnt == TRB_W'(TURBO_MAX - 1)) begin
            armed_next     = 1'b0;
            turbo_cnt_next = turbo_cnt + TRB_W'(1);
        end else begin
            turbo_next = 1'b1;
            if (TurboAct_out) begin
                turbo_cnt_next = turbo_cnt + TRB_W'(1);
            end
        end

        if (fault_next) begin
            state_next = FAULT;
        end else if (count_next == '0 && target_next == '0) begin
            state_next = IDLE;
        end else if (count_next < target_next) begin
            state_next = RAMP_UP;
        end else if (count_next > target_next) begin
            state_next = RAMP_DN;
        end else begin
            state_next = HOLD;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge Clk_in or posedge Rst_in) begin
        if (Rst_in) begin
            state        <= IDLE;
            count        <= '0;
            target       <= '0;
            div_cnt      <= '0;
            turbo_cnt    <= '0;
            err_cnt      <= '0;
            armed        <= 1'b1;
            TurboAct_out <= 1'b0;
            BGraph_out   <= '0;
            Busy_out     <= 1'b0;
            Err_out      <= 1'b0;
        end else begin
            state        <= state_next;
            count        <= count_next;
            target       <= target_next;
            div_cnt      <= div_next;
            turbo_cnt    <= turbo_cnt_next;
            err_cnt      <= err_cnt_next;
            armed        <= armed_next;
            TurboAct_out <= turbo_next;
            BGraph_out   <= BAR_W'(therm_code(CNT_W'(count_next), BAR_W));
            Busy_out     <= (count_next != target_next);
            Err_out      <= fault_next;
        end
    end

endmodule

// File: tb/tb_thermo_ramp_bargraph.sv
// Self-checking bench: two builds (default and LEVELS=6/RAMP_DIV=1/TURBO_MAX=0)
// compared each cycle against a cycle-level integer model, plus directed spot checks.
module tb_thermo_ramp_bargraph;

    localparam int LA = 4, RA = 4, TA = 64, EA = 3;
    localparam int LB = 6, RB = 1, TB = 0,  EB = 3;

    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  th_a;
    logic [5:0]  th_b;
    logic        tu;
    logic [7:0]  g_a;
    logic [11:0] g_b;
    logic        err_a, err_b, ta_a, ta_b, busy_a, busy_b;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    thermo_ramp_bargraph #(.LEVELS(LA), .BAR_W(2*LA), .RAMP_DIV(RA), .TURBO_MAX(TA), .ERR_CYC(EA)) dut_a (
        .Clk_in(clk), .Rst_in(rst), .Thermo_in(th_a), .Turbo_in(tu),
        .BGraph_out(g_a), .Err_out(err_a), .TurboAct_out(ta_a), .Busy_out(busy_a)
    );

    thermo_ramp_bargraph #(.LEVELS(LB), .BAR_W(2*LB), .RAMP_DIV(RB), .TURBO_MAX(TB), .ERR_CYC(EB)) dut_b (
        .Clk_in(clk), .Rst_in(rst), .Thermo_in(th_b), .Turbo_in(tu),
        .BGraph_out(g_b), .Err_out(err_b), .TurboAct_out(ta_b), .Busy_out(busy_b)
    );

    typedef struct {
        int bars, tgt, div, tcnt, filt;
        bit armed, tact, fault;
    } mdl_t;

    mdl_t ma, mb;

    function automatic mdl_t mdl_reset();
        mdl_t m;
        m.bars = 0; m.tgt = 0; m.div = 0; m.tcnt = 0; m.filt = 0;
        m.armed = 1; m.tact = 0; m.fault = 0;
        return m;
    endfunction

    // One clock of the behaviour: each rule reads the old values and writes the new ones.
    function automatic mdl_t mdl_step(mdl_t s, logic [31:0] th, int levels, bit t,
                                      int rdiv, int tmax, int ecyc);
        mdl_t n = s;
        int   ones = $countones(th);
        int   lvl = 0;
        bit   valid = (ones <= 1);
        bit   match = s.fault ? valid : !valid;
        for (int k = 0; k < levels; k++) if (th[k]) lvl = k;

        if (match) begin
            n.filt = s.filt + 1;
            if (n.filt == ecyc) begin
                n.fault = !s.fault;
                n.filt  = 0;
            end
        end else begin
            n.filt = 0;
        end

        if (s.fault)     n.tgt = 0;
        else if (valid)  n.tgt = (th == 0) ? 0 : 2 * lvl + 1 + (s.tact ? 1 : 0);

        if (s.bars != s.tgt) begin
            if (s.div == rdiv - 1) begin
                n.bars = s.bars + ((s.bars < s.tgt) ? 1 : -1);
                n.div  = 0;
            end else begin
                n.div = s.div + 1;
            end
        end else begin
            n.div = 0;
        end

        if (!t) begin
            n.armed = 1; n.tcnt = 0; n.tact = 0;
        end else if (s.fault || !s.armed) begin
            n.tact = 0;
        end else if (tmax == 0) begin
            n.tact = 1;
        end else if (s.tact && s.tcnt + 1 >= tmax) begin
            n.tact = 0; n.armed = 0; n.tcnt = tmax;
        end else begin
            n.tact = 1;
            if (s.tact) n.tcnt = s.tcnt + 1;
        end
        return n;
    endfunction

    function automatic logic [31:0] bars_code(int n);
        return 32'((64'd1 << n) - 64'd1);
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic compare_all();
        check("a_graph", 32'(g_a),    bars_code(ma.bars));
        check("a_busy",  32'(busy_a), 32'(ma.bars != ma.tgt));
        check("a_err",   32'(err_a),  32'(ma.fault));
        check("a_tact",  32'(ta_a),   32'(ma.tact));
        check("b_graph", 32'(g_b),    bars_code(mb.bars));
        check("b_busy",  32'(busy_b), 32'(mb.bars != mb.tgt));
        check("b_err",   32'(err_b),  32'(mb.fault));
        check("b_tact",  32'(ta_b),   32'(mb.tact));
    endtask

    // Called on a falling edge; drives inputs, advances both models, compares at the next falling edge.
    task automatic run(input logic [3:0] a, input logic [5:0] b, input logic t, input int n);
        for (int i = 0; i < n; i++) begin
            th_a = a; th_b = b; tu = t;
            ma = mdl_step(ma, 32'(a), LA, t, RA, TA, EA);
            mb = mdl_step(mb, 32'(b), LB, t, RB, TB, EB);
            @(negedge clk);
            compare_all();
        end
    endtask

    initial begin
        logic [3:0] ra;
        logic [5:0] rb;
        logic       rt;
        rst = 1'b1; th_a = '0; th_b = '0; tu = 1'b0;
        ma = mdl_reset(); mb = mdl_reset();
        #12;
        compare_all();
        @(negedge clk);
        rst = 1'b0;

        // Ramp part way up, then asynchronous reset between clock edges.
        run(4'b1000, 6'b100000, 1'b0, 21);
        check("a_mid_ramp_5bars", 32'(g_a), 32'h1F);
        #2 rst = 1'b1;
        #1;
        ma = mdl_reset(); mb = mdl_reset();
        compare_all();
        @(negedge clk);
        rst = 1'b0;

        // Clean ramp from zero: seven bars after 1 + 7*4 cycles.
        run(4'b1000, 6'b100000, 1'b0, 28);
        check("a_ramp_28", 32'(g_a), 32'h3F);
        check("a_busy_28", 32'(busy_a), 32'h1);
        run(4'b1000, 6'b100000, 1'b0, 1);
        check("a_ramp_29", 32'(g_a), 32'h7F);
        check("a_busy_29", 32'(busy_a), 32'h0);

        // Turbo at level 1, expiry after 64 cycles, no retrigger, rearm after a low pulse.
        run(4'b0010, 6'b100000, 1'b0, 20);
        check("a_hold3", 32'(g_a), 32'h07);
        run(4'b0010, 6'b100000, 1'b1, 8);
        check("a_turbo4", 32'(g_a), 32'h0F);
        run(4'b0010, 6'b100000, 1'b1, 70);
        check("a_turbo_expired", 32'(ta_a), 32'h0);
        check("a_back_to_3", 32'(g_a), 32'h07);
        check("b_turbo_unlimited", 32'(ta_b), 32'h1);
        check("b_top_turbo_12", 32'(g_b), 32'hFFF);
        run(4'b0010, 6'b100000, 1'b0, 1);
        run(4'b0010, 6'b100000, 1'b1, 10);
        check("a_turbo_rearm", 32'(ta_a), 32'h1);
        check("a_turbo_rearm_4", 32'(g_a), 32'h0F);

        // Ramp down with a mid-descent reversal.
        run(4'b1000, 6'b000100, 1'b0, 30);
        check("a_top7", 32'(g_a), 32'h7F);
        run(4'b0001, 6'b000001, 1'b0, 13);
        check("a_down_at4", 32'(g_a), 32'h0F);
        run(4'b0100, 6'b000100, 1'b0, 4);
        check("a_reversed_5", 32'(g_a), 32'h1F);

        // Short glitch is filtered; a long one latches fault.
        run(4'b0101, 6'b000101, 1'b0, 2);
        run(4'b0100, 6'b000100, 1'b0, 4);
        check("a_glitch_no_err", 32'(err_a), 32'h0);
        check("a_glitch_held", 32'(g_a), 32'h1F);
        run(4'b0101, 6'b000101, 1'b1, 3);
        check("a_fault_entry", 32'(err_a), 32'h1);
        run(4'b0101, 6'b000101, 1'b1, 25);
        check("a_fault_graph0", 32'(g_a), 32'h00);
        check("a_fault_no_turbo", 32'(ta_a), 32'h0);
        run(4'b0010, 6'b000010, 1'b0, 3);
        check("a_fault_exit", 32'(err_a), 32'h0);
        run(4'b0010, 6'b000010, 1'b0, 20);
        check("a_after_fault_3", 32'(g_a), 32'h07);

        // Randomised segments: mostly valid codes, some glitches, turbo mostly held.
        for (int s = 0; s < 300; s++) begin
            if ($urandom_range(0, 9) < 7)
                ra = ($urandom_range(0, 4) == 0) ? 4'b0 : 4'(1 << $urandom_range(0, 3));
            else
                ra = 4'($urandom);
            if ($urandom_range(0, 9) < 7)
                rb = ($urandom_range(0, 6) == 0) ? 6'b0 : 6'(1 << $urandom_range(0, 5));
            else
                rb = 6'($urandom);
            rt = ($urandom_range(0, 9) < 8);
            run(ra, rb, rt, int'($urandom_range(1, 12)));
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/thermo_ramp_bargraph.md
Name: thermo_ramp_bargraph

Overview:
Parametrised, clocked successor to the combinational thermostat bar-graph decoder. It maps a one-hot thermostat demand level plus a turbo request to a thermometer-coded bar graph. The graph soft-ramps one bar at a time toward the target instead of jumping. It adds a time-limited turbo and a glitch-filtered error/fault mode. It sits between the thermostat input decode and the front-panel LED bar.

Parameters:
LEVELS, 4, number of one-hot demand levels (>=2).
BAR_W, 2*LEVELS, bar-graph width; fixed at 2*LEVELS.
RAMP_DIV, 4, clock cycles per one-bar ramp step (>=1).
TURBO_MAX, 64, max consecutive cycles turbo stays active; 0 = unlimited.
ERR_CYC, 3, consecutive cycles required to enter or leave fault (>=1).

Ports:
Clk_in  input  1  system clock, rising edge.
Rst_in  input  1  reset, asynchronous, active-high.
Thermo_in  input  LEVELS  one-hot demand (bit k = level k); all-zero = OFF.
Turbo_in  input  1  turbo request, level-sensitive.
BGraph_out  output  BAR_W  thermometer bar graph; lowest N bits set for N bars.
Err_out  output  1  fault indicator (invalid Thermo_in code, filtered).
TurboAct_out  output  1  turbo currently applied.
Busy_out  output  1  bar count differs from target (ramping).

Behaviour:
- Reset (async, Rst_in=1): BGraph_out=0, Err_out=0, TurboAct_out=0, Busy_out=0, bar count=0, all counters=0, state=IDLE, turbo armed. Assert mid-ramp -> immediate clear, no residual step.
- Valid input: zero or exactly one bit set. Invalid input: two or more bits set.
- Target: OFF -> 0 bars. Level k -> 2k+1 bars, or 2k+2 if TurboAct_out=1. Target is registered; 1-cycle latency from input to target.
- Turbo: TurboAct_out=1 while Turbo_in=1, turbo armed, and not in fault.
  - Cycle counter increments while TurboAct_out=1.
  - When counter reaches TURBO_MAX (TURBO_MAX>0): TurboAct_out drops and turbo disarms.
  - Turbo rearms and the counter clears once Turbo_in=0 for >=1 cycle.
  - Turbo with OFF input: TurboAct_out may be 1, but the target stays 0.
- Ramp:
  - Divider counts only while count != target; it is held at 0 when equal.
  - When the divider reaches RAMP_DIV-1: count moves one bar toward target and the divider resets.
  - A target change mid-ramp does not reset the divider; the direction re-evaluates on each step.
  - Count is never outside 0..BAR_W.
- States:
  - IDLE: count=0, target=0.
  - RAMP_UP: count<target.
  - RAMP_DN: count>target.
  - HOLD: count=target!=0.
  - FAULT: error latched.
  - Transitions follow the count/target comparison each cycle. FAULT takes priority over all other states.
- Fault:
  - An invalid code for ERR_CYC consecutive cycles enters FAULT and sets Err_out=1.
  - In FAULT: target forced to 0, graph ramps down, turbo suppressed.
  - A valid code for ERR_CYC consecutive cycles exits FAULT and clears Err_out; the target is then re-evaluated normally.
  - Any non-matching cycle restarts the respective filter count.
  - While not in fault, an invalid code shorter than ERR_CYC holds the previous valid target.
- Outputs:
  - BGraph_out is the registered thermometer code of the count.
  - Busy_out = (count != target), registered alongside the count.
- Widths: count and target use clog2(BAR_W+1) bits. Divider, turbo and error counters are sized to their parameter, with a minimum of 1 bit.

Decomposition:
- Package thermo_pkg holds:
  - state enum {IDLE, RAMP_UP, RAMP_DN, HOLD, FAULT};
  - function onehot_valid(vec) returning the valid flag and level index;
  - function therm_code(count, BAR_W);
  - localparam CNT_W = clog2(BAR_W+1).
- One sub-module thermo_level_decode: combinational one-hot validation and level-to-target mapping (with turbo). The top holds all sequential logic.

Test Plan:
- Reset/ramp-up: defaults, Thermo_in=4'b1000, Turbo_in=0 from reset -> BGraph_out steps 0->1->...->7 every 4 cycles, 8'b01111111 about 1+7*4 cycles after input; Busy_out=1 during the ramp, then 0.
- Turbo: in HOLD at level 1 (3 bars), Turbo_in=1 -> one step to 4 bars (8'b00001111). After 64 turbo cycles TurboAct_out=0 and the graph ramps back to 3. Hold Turbo_in=1 -> no re-trigger. Pulse Turbo_in=0 for 1 cycle then 1 -> turbo reapplies.
- Ramp-down/reversal: at 7 bars, switch to 4'b0001 -> ramps to 1. Switch to 4'b0100 mid-descent at 4 bars -> direction reverses toward 5 with no extra delay beyond the divider.
- Glitch/fault: 4'b0101 for 2 cycles -> no Err_out, target held. 4'b0101 for 3 cycles -> Err_out=1, graph ramps to 0, TurboAct_out=0. Valid 4'b0010 for 3 cycles -> Err_out=0, graph ramps to 3.
- Reset mid-operation: assert Rst_in asynchronously mid-ramp at 5 bars -> all outputs 0 immediately without a clock edge. Release -> clean ramp from 0.
- Parameter sweep: LEVELS=6, RAMP_DIV=1, TURBO_MAX=0 -> top level with turbo gives 12 bars, one bar per cycle, turbo never expires.
